secure_xfer_ctrl: RTL and testbench

Sequencer and arbiter for secured transfers between the register file and data memory. Two requesters, load (memory→register) and store (register→memory), share one transfer path. Each granted request presents a 16-bit access key. The block checks that key against a programmable key register and then drives the read port of the source and the write port of the destination. The block replaces free-running address/key wiring at the top level with one controlled transaction at a time.

---
 rtl/secure_xfer_ctrl_pkg.sv | 16 +
 rtl/secure_xfer_ctrl_if.sv | 41 ++++
 rtl/secure_xfer_ctrl_rr_arb2.sv | 26 ++
 rtl/secure_xfer_ctrl.sv | 151 +++++++++++++++
 tb/tb_secure_xfer_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/secure_xfer_ctrl_pkg.sv
// Shared types and defaults for the secured register/memory transfer controller.
package sec_pkg;
    localparam int SEC_ADDR_W = 10;
    localparam int SEC_DATA_W = 32;
    localparam int SEC_KEY_W  = 16;
    localparam logic [SEC_KEY_W-1:0] SEC_KEY_RST = 16'hA5A5;

    typedef enum logic [2:0] {
        IDLE, KEY_CHK, READ, WAIT, WRITE, FAULT
    } xfer_state_t;

    typedef enum logic {
        DIR_LD = 1'b0,
        DIR_ST = 1'b1
    } xfer_dir_t;
endpackage

// File: rtl/secure_xfer_ctrl_if.sv
// Request, key-programming and memory/register port bundle of secure_xfer_ctrl.
interface secure_xfer_ctrl_if import sec_pkg::*; #(
    parameter int ADDR_W = SEC_ADDR_W,
    parameter int DATA_W = SEC_DATA_W,
    parameter int KEY_W  = SEC_KEY_W
) ();
    logic              ld_req, ld_ack, ld_err;
    logic [ADDR_W-1:0] ld_mem_addr, ld_reg_addr;
    logic [KEY_W-1:0]  ld_key;
    logic              st_req, st_ack, st_err;
    logic [ADDR_W-1:0] st_reg_addr, st_mem_addr;
    logic [KEY_W-1:0]  st_key;
    logic              key_wr_en;
    logic [KEY_W-1:0]  key_wr_data;
    logic              mem_rd_en, mem_wr_en, reg_rd_en, reg_wr_en;
    logic [ADDR_W-1:0] mem_rd_addr, mem_wr_addr, reg_rd_addr, reg_wr_addr;
    logic [DATA_W-1:0] mem_rd_data, mem_wr_data, reg_rd_data, reg_wr_data;
    logic              busy, locked;

    // Controller side.
    modport master (
        input  ld_req, ld_mem_addr, ld_reg_addr, ld_key,
        input  st_req, st_reg_addr, st_mem_addr, st_key,
        input  key_wr_en, key_wr_data, mem_rd_data, reg_rd_data,
        output ld_ack, ld_err, st_ack, st_err,
        output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        output reg_rd_en, reg_rd_addr, reg_wr_en, reg_wr_addr, reg_wr_data,
        output busy, locked
    );

    // Requesters, key programmer and storage side.
    modport slave (
        output ld_req, ld_mem_addr, ld_reg_addr, ld_key,
        output st_req, st_reg_addr, st_mem_addr, st_key,
        output key_wr_en, key_wr_data, mem_rd_data, reg_rd_data,
        input  ld_ack, ld_err, st_ack, st_err,
        input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        input  reg_rd_en, reg_rd_addr, reg_wr_en, reg_wr_addr, reg_wr_data,
        input  busy, locked
    );
endinterface

// File: rtl/secure_xfer_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; the last-grant pointer moves only when a grant is taken.
module rr_arb2 import sec_pkg::*; (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      req_ld,
    input  logic      req_st,
    input  logic      adv,
    output logic      gnt_vld,
    output xfer_dir_t gnt_dir
);
    xfer_dir_t last;

    assign gnt_vld = req_ld | req_st;

    always_comb begin
        gnt_dir = DIR_LD;
        if (req_ld && req_st) gnt_dir = (last == DIR_ST) ? DIR_LD : DIR_ST;
        else if (req_st)      gnt_dir = DIR_ST;
    end

    // Store as the reset pointer hands the first tie to load.
    always_ff @(posedge clk) begin
        if (!rst_n)              last <= DIR_ST;
        else if (adv && gnt_vld) last <= gnt_dir;
    end
endmodule

// File: rtl/secure_xfer_ctrl.sv
// Key-checked single-transaction sequencer between register file and data memory.
// Optional consecutive-failure lockout is built when SEC_LOCKOUT_EN is defined.
module secure_xfer_ctrl import sec_pkg::*; #(
    parameter int                ADDR_W      = SEC_ADDR_W,
    parameter int                DATA_W      = SEC_DATA_W,
    parameter int                KEY_W       = SEC_KEY_W,
    parameter int                RD_LAT      = 1,
    parameter logic [KEY_W-1:0]  KEY_RST     = SEC_KEY_RST,
    parameter int                LOCK_THRESH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    secure_xfer_ctrl_if.master bus
);
    if (RD_LAT < 1 || RD_LAT > 4 || LOCK_THRESH < 2 || LOCK_THRESH > 7) begin : g_cfg_chk
        $error("secure_xfer_ctrl: RD_LAT or LOCK_THRESH out of range");
    end

    xfer_state_t       state;
    xfer_dir_t         dir, gnt_dir;
    logic              gnt_vld, key_ok, locked;
    logic [ADDR_W-1:0] src_addr, dst_addr;
    logic [KEY_W-1:0]  cap_key, key_reg;
    logic [1:0]        wait_cnt;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_ld  (bus.ld_req),
        .req_st  (bus.st_req),
        .adv     (state == IDLE),
        .gnt_vld (gnt_vld),
        .gnt_dir (gnt_dir)
    );

    // Nonblocking update: KEY_CHK always sees the key from before a same-cycle write.
    always_ff @(posedge clk) begin
        if (!rst_n)             key_reg <= KEY_RST;
        else if (bus.key_wr_en) key_reg <= bus.key_wr_data;
    end

    assign key_ok = (cap_key == key_reg);

`ifdef SEC_LOCKOUT_EN
    logic [2:0] fail_cnt;
    logic       locked_q;

    always_ff @(posedge clk) begin
        if (!rst_n || bus.key_wr_en) begin
            fail_cnt <= '0;
            locked_q <= 1'b0;
        end else if (state == KEY_CHK) begin
            if (key_ok) begin
                fail_cnt <= '0;
            end else begin
                if (fail_cnt != 3'd7) fail_cnt <= fail_cnt + 3'd1;
                if (({1'b0, fail_cnt} + 4'd1) >= 4'(LOCK_THRESH)) locked_q <= 1'b1;
            end
        end
    end

    assign locked = locked_q;
`else
    assign locked = 1'b0;
`endif

    assign bus.locked = locked;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            dir             <= DIR_LD;
            src_addr        <= '0;
            dst_addr        <= '0;
            cap_key         <= '0;
            wait_cnt        <= '0;
            bus.busy        <= 1'b0;
            bus.ld_ack      <= 1'b0;
            bus.ld_err      <= 1'b0;
            bus.st_ack      <= 1'b0;
            bus.st_err      <= 1'b0;
            bus.mem_rd_en   <= 1'b0;
            bus.mem_rd_addr <= '0;
            bus.mem_wr_en   <= 1'b0;
            bus.mem_wr_addr <= '0;
            bus.mem_wr_data <= '0;
            bus.reg_rd_en   <= 1'b0;
            bus.reg_rd_addr <= '0;
            bus.reg_wr_en   <= 1'b0;
            bus.reg_wr_addr <= '0;
            bus.reg_wr_data <= '0;
        end else begin
            bus.ld_ack    <= 1'b0;
            bus.ld_err    <= 1'b0;
            bus.st_ack    <= 1'b0;
            bus.st_err    <= 1'b0;
            bus.mem_rd_en <= 1'b0;
            bus.mem_wr_en <= 1'b0;
            bus.reg_rd_en <= 1'b0;
            bus.reg_wr_en <= 1'b0;
            case (state)
                IDLE: if (gnt_vld) begin
                    dir      <= gnt_dir;
                    src_addr <= (gnt_dir == DIR_LD) ? bus.ld_mem_addr : bus.st_reg_addr;
                    dst_addr <= (gnt_dir == DIR_LD) ? bus.ld_reg_addr : bus.st_mem_addr;
                    cap_key  <= (gnt_dir == DIR_LD) ? bus.ld_key      : bus.st_key;
                    state    <= KEY_CHK;
                    bus.busy <= 1'b1;
                end
                KEY_CHK: if (key_ok && !locked) begin
                    // Strobe is registered here so it is high for the READ cycle.
                    if (dir == DIR_LD) begin
                        bus.mem_rd_en   <= 1'b1;
                        bus.mem_rd_addr <= src_addr;
                    end else begin
                        bus.reg_rd_en   <= 1'b1;
                        bus.reg_rd_addr <= src_addr;
                    end
                    wait_cnt <= 2'(RD_LAT - 1);
                    state    <= READ;
                end else begin
                    bus.ld_err <= (dir == DIR_LD);
                    bus.st_err <= (dir == DIR_ST);
                    state      <= FAULT;
                end
                READ: state <= WAIT;
                WAIT: if (wait_cnt == 2'd0) begin
                    // Last wait cycle: read data is valid now, launch the write and ack.
                    if (dir == DIR_LD) begin
                        bus.reg_wr_en   <= 1'b1;
                        bus.reg_wr_addr <= dst_addr;
                        bus.reg_wr_data <= bus.mem_rd_data;
                        bus.ld_ack      <= 1'b1;
                    end else begin
                        bus.mem_wr_en   <= 1'b1;
                        bus.mem_wr_addr <= dst_addr;
                        bus.mem_wr_data <= bus.reg_rd_data;
                        bus.st_ack      <= 1'b1;
                    end
                    state <= WRITE;
                end else begin
                    wait_cnt <= wait_cnt - 2'd1;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_secure_xfer_ctrl.sv
// Directed self-checking bench for secure_xfer_ctrl (RD_LAT=1, LOCK_THRESH=4).
module tb_secure_xfer_ctrl;
    import sec_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_val, reg_val;
    logic        wr_seen;
    int          n_tests = 0;
    int          n_fail  = 0;

    secure_xfer_ctrl_if #(.ADDR_W(10), .DATA_W(32), .KEY_W(16)) bus ();

    secure_xfer_ctrl #(
        .ADDR_W(10), .DATA_W(32), .KEY_W(16), .RD_LAT(1),
        .KEY_RST(16'hA5A5), .LOCK_THRESH(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Storage models: data is valid exactly one cycle after the strobe, garbage otherwise.
    always @(posedge clk) bus.mem_rd_data <= bus.mem_rd_en ? mem_val : 32'h0BAD0BAD;
    always @(posedge clk) bus.reg_rd_data <= bus.reg_rd_en ? reg_val : 32'h0BAD0BAD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ld_req = 0; bus.ld_mem_addr = '0; bus.ld_reg_addr = '0; bus.ld_key = '0;
        bus.st_req = 0; bus.st_reg_addr = '0; bus.st_mem_addr = '0; bus.st_key = '0;
        bus.key_wr_en = 0; bus.key_wr_data = '0;
        mem_val = '0; reg_val = '0; wr_seen = 0;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        chk("rst_busy",   bus.busy, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_strobes", {bus.mem_rd_en, bus.reg_rd_en, bus.mem_wr_en, bus.reg_wr_en}, 0);
        chk("rst_resp",   {bus.ld_ack, bus.ld_err, bus.st_ack, bus.st_err}, 0);
        chk("rst_wdata",  bus.reg_wr_data, 0);

        // Load with correct key
        bus.key_wr_en = 1; bus.key_wr_data = 16'h1234;
        cyc(1);
        bus.key_wr_en = 0;
        mem_val = 32'hDEADBEEF;
        bus.ld_mem_addr = 10'h055; bus.ld_reg_addr = 10'h0AA; bus.ld_key = 16'h1234;
        bus.ld_req = 1;
        cyc(1);
        chk("t1_busy_c1", bus.busy, 1);
        cyc(1);
        chk("t1_rd_en_c2", bus.mem_rd_en, 1);
        chk("t1_rd_addr",  bus.mem_rd_addr, 10'h055);
        chk("t1_err_c2",   bus.ld_err, 0);
        cyc(1);
        chk("t1_wr_early", bus.reg_wr_en, 0);
        cyc(1);
        chk("t1_wr_en_c4", bus.reg_wr_en, 1);
        chk("t1_wr_addr",  bus.reg_wr_addr, 10'h0AA);
        chk("t1_wr_data",  bus.reg_wr_data, 32'hDEADBEEF);
        chk("t1_ack_c4",   bus.ld_ack, 1);
        chk("t1_err_c4",   bus.ld_err, 0);
        bus.ld_req = 0;
        cyc(1);
        chk("t1_idle_busy", bus.busy, 0);
        chk("t1_ack_pulse", bus.ld_ack, 0);

        // Store with wrong key
        bus.st_key = 16'h0000; bus.st_reg_addr = 10'h033; bus.st_mem_addr = 10'h044;
        bus.st_req = 1;
        cyc(1);
        wr_seen = bus.mem_wr_en | bus.reg_wr_en;
        chk("t2_err_c1", bus.st_err, 0);
        cyc(1);
        wr_seen |= bus.mem_wr_en | bus.reg_wr_en;
        chk("t2_err_c2",  bus.st_err, 1);
        chk("t2_no_read", bus.reg_rd_en, 0);
        bus.st_req = 0;
        cyc(1);
        wr_seen |= bus.mem_wr_en | bus.reg_wr_en;
        chk("t2_err_pulse", bus.st_err, 0);
        chk("t2_busy_c3",   bus.busy, 0);
        chk("t2_no_write",  wr_seen, 0);

        // Simultaneous held requests after reset: load, store, load
        rst_n = 0;
        cyc(1);
        rst_n = 1;
        bus.ld_key = 16'hA5A5; bus.st_key = 16'hA5A5;
        reg_val = 32'hCAFEF00D;
        bus.ld_req = 1; bus.st_req = 1;
        cyc(4);
        chk("t3_g1_ld_ack", bus.ld_ack, 1);
        chk("t3_g1_st_ack", bus.st_ack, 0);
        chk("t3_g1_data",   bus.reg_wr_data, 32'hDEADBEEF);
        chk("t3_g1_memwr",  bus.mem_wr_en, 0);
        cyc(3);
        chk("t3_g2_rd_en",   bus.reg_rd_en, 1);
        chk("t3_g2_rd_addr", bus.reg_rd_addr, 10'h033);
        cyc(2);
        chk("t3_g2_st_ack",  bus.st_ack, 1);
        chk("t3_g2_ld_ack",  bus.ld_ack, 0);
        chk("t3_g2_wr_en",   bus.mem_wr_en, 1);
        chk("t3_g2_wr_addr", bus.mem_wr_addr, 10'h044);
        chk("t3_g2_wr_data", bus.mem_wr_data, 32'hCAFEF00D);
        cyc(5);
        chk("t3_g3_ld_ack", bus.ld_ack, 1);
        chk("t3_g3_st_ack", bus.st_ack, 0);
        bus.ld_req = 0; bus.st_req = 0;
        cyc(1);

        // Four consecutive bad keys
        bus.ld_key = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            bus.ld_req = 1;
            cyc(2);
            chk("t4_bad_err", bus.ld_err, 1);
            bus.ld_req = 0;
            cyc(1);
        end
`ifdef SEC_LOCKOUT_EN
        chk("t4_locked", bus.locked, 1);
        bus.ld_key = 16'hA5A5;
        bus.ld_req = 1;
        cyc(2);
        chk("t4_locked_err", bus.ld_err, 1);
        bus.ld_req = 0;
        cyc(1);
        bus.key_wr_en = 1; bus.key_wr_data = 16'hA5A5;
        cyc(1);
        bus.key_wr_en = 0;
        chk("t4_unlocked", bus.locked, 0);
        bus.ld_req = 1;
        cyc(4);
        chk("t4_unlock_ack", bus.ld_ack, 1);
        bus.ld_req = 0;
        cyc(1);
`else
        chk("t4_never_locked", bus.locked, 0);
        bus.ld_key = 16'hA5A5;
        bus.ld_req = 1;
        cyc(4);
        chk("t4_good_ack", bus.ld_ack, 1);
        bus.ld_req = 0;
        cyc(1);
`endif

        // Reset during WAIT discards the transfer and restores KEY_RST
        bus.key_wr_en = 1; bus.key_wr_data = 16'h7777;
        cyc(1);
        bus.key_wr_en = 0;
        bus.ld_key = 16'h7777;
        bus.ld_req = 1;
        cyc(3);
        chk("t5_in_wait", bus.busy, 1);
        rst_n = 0; bus.ld_req = 0;
        cyc(1);
        chk("t5_rst_ack",    bus.ld_ack, 0);
        chk("t5_rst_err",    bus.ld_err, 0);
        chk("t5_rst_wr",     bus.reg_wr_en, 0);
        chk("t5_rst_rd",     bus.mem_rd_en, 0);
        chk("t5_rst_busy",   bus.busy, 0);
        rst_n = 1;
        bus.ld_key = 16'hA5A5;
        bus.ld_req = 1;
        cyc(4);
        chk("t5_keyrst_ack", bus.ld_ack, 1);
        bus.ld_req = 0;
        cyc(1);

        // Key written during KEY_CHK is not yet visible
        bus.ld_key = 16'h4321;
        bus.ld_req = 1;
        cyc(1);
        bus.key_wr_en = 1; bus.key_wr_data = 16'h4321;
        cyc(1);
        bus.key_wr_en = 0;
        chk("t6_old_key_err", bus.ld_err, 1);
        chk("t6_old_key_rd",  bus.mem_rd_en, 0);
        bus.ld_req = 0;
        cyc(1);
        bus.ld_req = 1;
        cyc(4);
        chk("t6_new_key_ack", bus.ld_ack, 1);
        bus.ld_req = 0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
